rf_wr_arbiter: RTL
==================

# rf_wr_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). Pipeline writes normally win. MDU results queue in a small FIFO and drain into idle write slots. A starvation counter forces a one-cycle pipeline stall so queued results are guaranteed to retire. A per-register busy mask lets decode interlock on registers with queued writes.

## Interface
- WIDTH, 32, data width of register-file writes
- AW, 5, register address width (32 registers)
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive cycles the FIFO head may lose before a forced stall

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_wr_en  in  1  pipeline writeback request this cycle
- wb_addr  in  AW  pipeline destination register
- wb_data  in  WIDTH  pipeline write data
- wb_mode  in  2  0 word, 1 halfword, 2 byte
- wb_stall  out  1  pipeline must hold and re-present its WB request next cycle
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept (= not full)
- mdu_addr  in  AW  MDU destination register
- mdu_data  in  WIDTH  MDU result
- rf_wr_en  out  1  register-file write strobe
- rf_addr  out  AW  register-file write address
- rf_data  out  WIDTH  register-file write data
- rf_mode  out  2  register-file write mode
- busy_mask  out  2^AW  bit i set while any FIFO entry targets register i

## Operation
- Enqueue on an edge where mdu_valid && mdu_ready. mdu_ready = !full, combinational from FIFO state. Data is never dropped.
- Grant each cycle:
  - If wb_stall=1: drain the FIFO head. WB inputs are ignored.
  - Else if wb_wr_en=1: grant WB.
  - Else if FIFO non-empty: drain head.
  - Else no write.
- A drained MDU entry always uses rf_mode=0 (word).
- Starvation counter cnt, width clog2(STARVE_MAX+1):
  - Increments each cycle the FIFO is non-empty and WB is granted.
  - Clears on any drain, and whenever the FIFO is empty.
- wb_stall is registered. It is set on the edge where cnt reaches STARVE_MAX. It is high for exactly one cycle, then clears.
- busy_mask is the OR of one-hot(addr) over valid FIFO entries, decoded from registered FIFO state. It never reflects the current mdu_* inputs.
- Simultaneous enqueue and drain when full is not possible, because mdu_ready=0. When not full, the FIFO pointers advance independently.
- WAW ordering between pipeline and MDU is decode's responsibility via busy_mask. The arbiter does no address compare.

## Timing
- Reset (async, immediate): rf_wr_en=0, rf_addr=0, rf_data=0, rf_mode=0, wb_stall=0, busy_mask=0.
- During reset, mdu_ready=1. FIFO empty, cnt=0. Asserting reset mid-operation discards queued entries.
- rf_* are registered, so a grant in cycle N appears on rf_* in cycle N+1.
- Latency from MDU handshake to rf_wr_en:
  - 2 cycles minimum: enqueue edge, then drain cycle, then output register.
  - At most STARVE_MAX+2 cycles for the head entry.
- busy_mask bit sets in the cycle after the enqueue edge. It clears in the cycle after the drain edge, coincident with rf_wr_en for that entry.
- wb_stall asserts the cycle after cnt==STARVE_MAX is reached. In that cycle the head drains and cnt clears.
- wr_en on rf_* is low in any cycle with no grant. rf_addr, rf_data and rf_mode hold their last values.

## Test plan
- Reset, then idle: all outputs 0, mdu_ready=1. Hold 10 cycles: no change.
- WB only, wb_wr_en=1, addr=5, data=0xDEADBEEF, mode=2: next cycle rf_wr_en=1, rf_addr=5, rf_data=0xDEADBEEF, rf_mode=2. wb_stall stays 0.
- MDU push addr=7, data=0x12345678 with WB idle:
  - busy_mask[7]=1 one cycle after push.
  - rf write of 7/0x12345678, mode 0, appears 2 cycles after push.
  - busy_mask[7]=0 in that same cycle.
- Fill FIFO with 2 MDU pushes while wb_wr_en=1 every cycle:
  - mdu_ready=0 after the second push.
  - After 4 WB grants, wb_stall=1 for exactly one cycle and the first MDU entry is written.
  - The held WB request is written the following cycle.
- MDU push with wb_wr_en=1 in the same cycle to addr=3: WB write is granted first. The MDU entry drains on the first cycle with wb_wr_en=0.
- Assert rst_n=0 while FIFO holds 2 entries and rf_wr_en=1: outputs clear immediately, and busy_mask=0. After release, no stale write appears on rf_*.

Source files
------------

// File: rtl/rf_wr_arbiter_if.sv
// Write-port bundle shared by the pipeline writeback stage, the MDU result path
// and the register file.
interface rf_wr_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);
  logic             wb_wr_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [1:0]       wb_mode;
  logic             wb_stall;

  logic             mdu_valid;
  logic             mdu_ready;
  logic [AW-1:0]    mdu_addr;
  logic [WIDTH-1:0] mdu_data;

  logic             rf_wr_en;
  logic [AW-1:0]    rf_addr;
  logic [WIDTH-1:0] rf_data;
  logic [1:0]       rf_mode;

  logic [(2**AW)-1:0] busy_mask;

  // Requesters and register file side
  modport master (
    output wb_wr_en, wb_addr, wb_data, wb_mode,
    output mdu_valid, mdu_addr, mdu_data,
    input  wb_stall, mdu_ready,
    input  rf_wr_en, rf_addr, rf_data, rf_mode, busy_mask
  );

  // Arbiter side
  modport slave (
    input  wb_wr_en, wb_addr, wb_data, wb_mode,
    input  mdu_valid, mdu_addr, mdu_data,
    output wb_stall, mdu_ready,
    output rf_wr_en, rf_addr, rf_data, rf_mode, busy_mask
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results
// queue in a small FIFO and drain into idle slots, with a starvation-forced stall.
module rf_wr_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rf_wr_arbiter_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned QW = PW + 1;
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam int unsigned NR = 2**AW;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_MDU
  } grant_t;

  logic [AW-1:0]    q_addr [DEPTH];
  logic [WIDTH-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [QW-1:0]    q_count;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             stall_q;

  logic             wr_en_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       mode_q;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  grant_t           grant;
  logic [NR-1:0]    busy;

  assign empty = (q_count == '0);
  assign full  = (q_count == QW'(DEPTH));
  assign push  = bus.mdu_valid && !full;
  assign pop   = (grant == GNT_MDU);

  // A stall cycle belongs to the FIFO head; the WB request is re-presented later.
  always_comb begin
    grant = GNT_NONE;
    if (stall_q) begin
      if (!empty) grant = GNT_MDU;
    end else if (bus.wb_wr_en) begin
      grant = GNT_WB;
    end else if (!empty) begin
      grant = GNT_MDU;
    end
  end

  always_comb begin
    cnt_next = cnt;
    if (empty || pop) begin
      cnt_next = '0;
    end else if (grant == GNT_WB) begin
      cnt_next = cnt + CW'(1);
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (q_valid[i]) busy[q_addr[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.mdu_addr;
      q_data[wr_ptr] <= bus.mdu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      q_valid <= '0;
    end else begin
      if (push) begin
        q_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + QW'(1);
        2'b01:   q_count <= q_count - QW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      stall_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mode_q  <= '0;
    end else begin
      cnt     <= cnt_next;
      stall_q <= (cnt_next == CW'(STARVE_MAX));
      case (grant)
        GNT_WB: begin
          wr_en_q <= 1'b1;
          addr_q  <= bus.wb_addr;
          data_q  <= bus.wb_data;
          mode_q  <= bus.wb_mode;
        end
        GNT_MDU: begin
          wr_en_q <= 1'b1;
          addr_q  <= q_addr[rd_ptr];
          data_q  <= q_data[rd_ptr];
          mode_q  <= 2'd0;
        end
        default: begin
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_stall  = stall_q;
  assign bus.mdu_ready = !full;
  assign bus.rf_wr_en  = wr_en_q;
  assign bus.rf_addr   = addr_q;
  assign bus.rf_data   = data_q;
  assign bus.rf_mode   = mode_q;
  assign bus.busy_mask = busy;
endmodule
